// File: rtl/fft_bitrev_buf_if.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buf_if
//
// Stream bundle for the bit-reversal reorder buffer. It carries both
// handshakes: the natural-order input stream and the bit-reversed output
// stream.
//
//   in_valid / in_ready   : input handshake; a sample transfers when both are high
//   in_r / in_i           : input sample, signed real / imaginary parts
//   out_valid / out_ready : output handshake; a sample transfers when both are high
//   out_r / out_i         : output sample, signed real / imaginary parts
//   out_idx               : natural-order index of the sample on out_r/out_i
//   out_last              : high with the final sample of a frame
//
// Modports:
//   slave  : the buffer side; it consumes in_*, produces out_*
//   master : the environment side; it produces in_*, consumes out_*
// -----------------------------------------------------------------------------
interface fft_bitrev_buf_if #(
  parameter int LOG2N = 4,
  parameter int DW    = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_r;
  logic signed [DW-1:0]  in_i;

  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  out_r;
  logic signed [DW-1:0]  out_i;
  logic [LOG2N-1:0]      out_idx;
  logic                  out_last;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_idx, out_last
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_idx, out_last
  );
endinterface

// File: rtl/fft_bitrev_buf.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buf
//
// Ping-pong reorder buffer that sits directly in front of the radix-2 DIT
// butterfly datapath. Complex samples arrive in natural order. Each N-point
// frame (N = 2**LOG2N) is re-emitted in bit-reversed index order. Two N-entry
// banks let one frame be written while the previous frame is read. Data pass
// through bit-exact.
//
// Parameters:
//   LOG2N : log2 of the frame length (2..10)
//   DW    : width of each sample component (Q15 when DW = 16)
//
// Ports:
//   clk : single clock; all state changes on the rising edge
//   rst : synchronous, active-high reset; discards both banks and any
//         partial frame
//   bus : fft_bitrev_buf_if.slave. The input handshake is in_valid/in_ready
//         with in_r/in_i. The output handshake is out_valid/out_ready with
//         out_r/out_i/out_idx/out_last.
//
// Timing:
//   in_ready depends only on state, never on in_valid.
//   Bank status is registered, and so are the outputs. The first output of a
//   frame therefore goes valid one edge after the edge that accepts the
//   frame's last input, provided the read side is idle.
//   Each side sustains one sample per clock.
// -----------------------------------------------------------------------------
module fft_bitrev_buf #(
  parameter int LOG2N = 4,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  fft_bitrev_buf_if.slave  bus
);

  localparam int                N        = 1 << LOG2N;
  localparam logic [LOG2N-1:0]  CNT_LAST = LOG2N'(N - 1);

  typedef logic [2*DW-1:0] word_t;   // {real, imag}

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Bank storage. The bank select is the MSB of the address.
  word_t             mem_q [2*N];

  logic [1:0]        full_q,      full_d;       // bank holds a complete frame
  logic              wb_q,        wb_d;         // bank being written
  logic              rb_q,        rb_d;         // bank being read
  logic [LOG2N-1:0]  wcnt_q,      wcnt_d;       // natural-order write position
  logic [LOG2N-1:0]  rcnt_q,      rcnt_d;       // read count (bit-reversed for address)

  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_r_q,     out_r_d;
  logic [DW-1:0]     out_i_q,     out_i_d;
  logic [LOG2N-1:0]  out_idx_q,   out_idx_d;
  logic              out_last_q,  out_last_d;

  // ---------------------------------------------------------------------------
  // Bit reversal: pure wiring, bitrev(k)[j] = k[LOG2N-1-j]
  // ---------------------------------------------------------------------------
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int j = 0; j < LOG2N; j++) begin
      r[j] = k[LOG2N-1-j];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic              in_ready;
  logic              wr_en;
  logic              ld;
  logic              out_fire;
  logic [LOG2N-1:0]  rd_idx;
  word_t             rd_word;

  assign in_ready = !full_q[wb_q];
  assign wr_en    = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  // Refill the output register whenever it is empty or being consumed.
  assign ld       = full_q[rb_q] && (!out_valid_q || bus.out_ready);
  assign rd_idx   = bitrev(rcnt_q);
  // A write needs !full[wb] and a read needs full[rb]. A same-cycle read and
  // write can therefore never address the same bank.
  assign rd_word  = mem_q[{rb_q, rd_idx}];

  // ---------------------------------------------------------------------------
  // Bank write port
  // ---------------------------------------------------------------------------
  // NOTE: storage is deliberately left out of reset; the full flags say
  // which contents are meaningful, so a reset only has to clear the flags.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wb_q, wcnt_q}] <= {bus.in_r, bus.in_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block
    // leaves a signal unassigned (no latches); blocking '=' is correct in
    // combinational logic, while the registers below use '<='.
    full_d      = full_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    // Write side: the counter wraps naturally from N-1 to 0.
    if (wr_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == CNT_LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = !wb_q;
      end
    end

    // Read side. A release always targets the other bank from a write
    // completion, so both flag updates can apply in the same cycle.
    if (ld) begin
      out_r_d     = rd_word[2*DW-1:DW];
      out_i_d     = rd_word[DW-1:0];
      out_idx_d   = rd_idx;
      out_last_d  = (rcnt_q == CNT_LAST);
      out_valid_d = 1'b1;
      rcnt_d      = rcnt_q + 1'b1;
      if (rcnt_q == CNT_LAST) begin
        full_d[rb_q] = 1'b0;
        rb_d         = !rb_q;
      end
    end else if (out_fire) begin
      // The sample was taken and nothing replaces it. The data registers keep
      // their value; only valid drops.
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_buf
//
// Scoreboard bench for fft_bitrev_buf. Two instances are used:
//   A : LOG2N = 4
//   B : LOG2N = 2
// Each sample accepted at the input is collected into a frame. When a frame
// is complete, the reference model reorders it by arithmetic bit reversal and
// queues the expected outputs. A negedge monitor pops and compares on every
// output handshake.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_buf;

  localparam int LA = 4;
  localparam int NA = 1 << LA;
  localparam int LB = 2;
  localparam int NB = 1 << LB;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_buf_if #(.LOG2N(LA), .DW(DW)) bus_a ();
  fft_bitrev_buf_if #(.LOG2N(LB), .DW(DW)) bus_b ();

  fft_bitrev_buf #(.LOG2N(LA), .DW(DW)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fft_bitrev_buf #(.LOG2N(LB), .DW(DW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Output-ready control: directed value or per-cycle random (A only).
  logic rdy_a = 1'b1, rr_a = 1'b1, rand_rdy = 1'b0, rdy_b = 1'b1;
  assign bus_a.out_ready = rand_rdy ? rr_a : rdy_a;
  assign bus_b.out_ready = rdy_b;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rr_a = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    int          idx;
    bit          last;
  } exp_t;
  typedef exp_t exp_q_t[$];

  exp_t        q_a[$], q_b[$];
  logic [31:0] part_a[$], part_b[$];
  int          hs_cyc_a[$];
  logic [15:0] obs_r_a[$];
  int          obs_idx_b[$];
  int          cyc = 0;
  int          acc_a = 0;
  int          drop_a = 0;
  bit          watch_a = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: bit reversal by plain arithmetic.
  function automatic int bitrev_ref(input int k, input int bits);
    int res = 0;
    int v = k;
    repeat (bits) begin
      res = res * 2 + v % 2;
      v = v / 2;
    end
    return res;
  endfunction

  function automatic exp_q_t reorder(input logic [31:0] fr[$], input int bits);
    exp_q_t res;
    for (int j = 0; j < fr.size(); j++) begin
      int   k;
      exp_t e;
      k      = bitrev_ref(j, bits);
      e.r    = fr[k][31:16];
      e.i    = fr[k][15:0];
      e.idx  = k;
      e.last = (j == fr.size() - 1);
      res.push_back(e);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (negedge: away from the active edge)
  // ---------------------------------------------------------------------------
  exp_t   e_a, e_b;
  exp_q_t f_a, f_b;

  always @(negedge clk) begin
    if (rst) begin
      q_a.delete(); part_a.delete();
      q_b.delete(); part_b.delete();
    end else begin
      // A output
      if (bus_a.out_valid && bus_a.out_ready) begin
        hs_cyc_a.push_back(cyc);
        obs_r_a.push_back(bus_a.out_r);
        if (q_a.size() == 0) begin
          check("a_spurious_output", 32'(bus_a.out_idx), 32'hFFFF_FFFF);
        end else begin
          e_a = q_a.pop_front();
          check("a_data", {bus_a.out_r, bus_a.out_i}, {e_a.r, e_a.i});
          check("a_idx", 32'(bus_a.out_idx), 32'(e_a.idx));
          check("a_last", 32'(bus_a.out_last), 32'(e_a.last));
        end
      end
      // A input
      if (watch_a && bus_a.in_valid && !bus_a.in_ready) drop_a++;
      if (bus_a.in_valid && bus_a.in_ready) begin
        acc_a++;
        part_a.push_back({bus_a.in_r, bus_a.in_i});
        if (part_a.size() == NA) begin
          f_a = reorder(part_a, LA);
          foreach (f_a[j]) q_a.push_back(f_a[j]);
          part_a.delete();
        end
      end
      // B output
      if (bus_b.out_valid && bus_b.out_ready) begin
        obs_idx_b.push_back(int'(bus_b.out_idx));
        if (q_b.size() == 0) begin
          check("b_spurious_output", 32'(bus_b.out_idx), 32'hFFFF_FFFF);
        end else begin
          e_b = q_b.pop_front();
          check("b_data", {bus_b.out_r, bus_b.out_i}, {e_b.r, e_b.i});
          check("b_idx", 32'(bus_b.out_idx), 32'(e_b.idx));
          check("b_last", 32'(bus_b.out_last), 32'(e_b.last));
        end
      end
      // B input
      if (bus_b.in_valid && bus_b.in_ready) begin
        part_b.push_back({bus_b.in_r, bus_b.in_i});
        if (part_b.size() == NB) begin
          f_b = reorder(part_b, LB);
          foreach (f_b[j]) q_b.push_back(f_b[j]);
          part_b.delete();
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // Present one sample and hold it until accepted, then idle for 'gap'
  // cycles. Called and returning at posedge + 1.
  task automatic send(input bit sel, input logic [15:0] r, input logic [15:0] i, input int gap);
    bit acc = 1'b0;
    int t   = 0;
    if (sel) begin bus_b.in_valid = 1'b1; bus_b.in_r = r; bus_b.in_i = i; end
    else     begin bus_a.in_valid = 1'b1; bus_a.in_r = r; bus_a.in_i = i; end
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = sel ? bus_b.in_ready : bus_a.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("in_accept_timeout", 32'(t), 32'd0);
    if (gap > 0 || !acc) begin
      if (sel) bus_b.in_valid = 1'b0; else bus_a.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle_in();
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel);
    int t = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(sel ? "b_drain" : "a_drain", 32'(sel ? q_b.size() : q_a.size()), 32'd0);
  endtask

  task automatic check_order16(input string name, input int base);
    int ord [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int j = 0; j < 16; j++) begin
      if (base + j < obs_r_a.size()) check(name, 32'(obs_r_a[base + j]), 32'(ord[j]));
      else check(name, 32'hDEAD, 32'(ord[j]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base, hbase;
    logic [15:0] rv, iv;
    bus_a.in_valid = 1'b0; bus_a.in_r = '0; bus_a.in_i = '0;
    bus_b.in_valid = 1'b0; bus_b.in_r = '0; bus_b.in_i = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rst_out_data",  {bus_a.out_r, bus_a.out_i}, 32'd0);
    check("rst_out_idx",   32'(bus_a.out_idx),   32'd0);
    check("rst_out_last",  32'(bus_a.out_last),  32'd0);
    check("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);

    // 1. Single frame k / -k, latency
    base = obs_r_a.size();
    for (int k = 0; k < NA; k++) send(1'b0, 16'(k), 16'(-k), 0);
    idle_in();
    @(negedge clk);
    check("latency_not_early", 32'(bus_a.out_valid), 32'd0);
    @(negedge clk);
    check("latency_one_edge", 32'(bus_a.out_valid), 32'd1);
    check("latency_first_idx", 32'(bus_a.out_idx), 32'd0);
    @(posedge clk); #1;
    wait_drain(1'b0);
    check_order16("single_order", base);

    // 2. Back-to-back frames, continuous valid
    base  = obs_r_a.size();
    hbase = hs_cyc_a.size();
    drop_a = 0;
    watch_a = 1'b1;
    for (int k = 0; k < NA; k++) send(1'b0, 16'(k), 16'(-k), 0);
    for (int k = 0; k < NA; k++) send(1'b0, 16'(100 + k), 16'(-(100 + k)), 0);
    idle_in();
    watch_a = 1'b0;
    check("b2b_in_ready_never_low", 32'(drop_a), 32'd0);
    wait_drain(1'b0);
    check("b2b_gap_free",
          (hs_cyc_a.size() >= hbase + 2*NA) ? 32'(hs_cyc_a[hbase + 2*NA - 1] - hs_cyc_a[hbase]) : 32'hFFFF,
          32'(2*NA - 1));
    check_order16("b2b_frame1_order", base);

    // 3. Backpressure: out_ready low for 40 cycles, 3 frames offered
    rdy_a = 1'b0;
    base = acc_a;
    fork
      begin
        for (int k = 0; k < 3*NA; k++) send(1'b0, 16'(k), 16'(k ^ 16'h5A5A), 0);
        idle_in();
      end
      begin
        repeat (40) begin @(posedge clk); #1; end
        @(negedge clk);
        check("bp_accepted", 32'(acc_a - base), 32'(2*NA));
        check("bp_in_ready_low", 32'(bus_a.in_ready), 32'd0);
        check("bp_out_valid_held", 32'(bus_a.out_valid), 32'd1);
        check("bp_out_r_held", 32'(bus_a.out_r), 32'd0);
        @(posedge clk); #1;
        rdy_a = 1'b1;
      end
    join
    wait_drain(1'b0);

    // 4. Input stall: valid toggles
    base = obs_r_a.size();
    for (int k = 0; k < NA; k++) send(1'b0, 16'(k), 16'(-k), 1);
    wait_drain(1'b0);
    check_order16("stall_order", base);

    // 5. Reset mid-frame with a full frame parked and 7 partial samples
    rdy_a = 1'b0;
    for (int k = 0; k < NA + 7; k++) send(1'b0, 16'(500 + k), 16'(k), 0);
    idle_in();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rstmid_in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rstmid_out_data",  {bus_a.out_r, bus_a.out_i}, 32'd0);
    rst = 1'b0;
    rdy_a = 1'b1;
    base = obs_r_a.size();
    for (int k = 0; k < NA; k++) send(1'b0, 16'(k), 16'(-k), 0);
    idle_in();
    wait_drain(1'b0);
    check_order16("rstmid_fresh_order", base);

    // 6. Extremes
    for (int k = 0; k < NA; k++)
      send(1'b0, k[0] ? 16'h7FFF : 16'h8000, k[0] ? 16'h8000 : 16'h7FFF, 0);
    idle_in();
    wait_drain(1'b0);

    // 7. Random frames, random gaps, random out_ready
    rand_rdy = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NA; k++) begin
        rv = 16'($urandom);
        iv = 16'($urandom);
        send(1'b0, rv, iv, int'($urandom_range(0, 2)));
      end
    end
    idle_in();
    rand_rdy = 1'b0;
    wait_drain(1'b0);

    // 8. LOG2N = 2 instance: order 0,2,1,3, then extremes
    base = obs_idx_b.size();
    for (int k = 0; k < NB; k++) send(1'b1, 16'(k), 16'(-k), 0);
    idle_in();
    for (int k = 0; k < NB; k++)
      send(1'b1, k[0] ? 16'h7FFF : 16'h8000, k[0] ? 16'h8000 : 16'h7FFF, 0);
    idle_in();
    wait_drain(1'b1);
    begin
      int ordb [4] = '{0, 2, 1, 3};
      for (int j = 0; j < 4; j++)
        check("b_order", (base + j < obs_idx_b.size()) ? 32'(obs_idx_b[base + j]) : 32'hDEAD,
              32'(ordb[j]));
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
